// File: rtl/dmem_pkg.sv
// Shared types for the sized data memory: access-size and FSM-state encodings,
// plus small helpers that turn an access size into lane masks and bit counts.
package dmem_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        HALF  = 2'b01,
        WORD  = 2'b10,
        DWORD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } dmem_state_e;

    // Byte-enable pattern for an access of this size sitting at lane 0.
    function automatic logic [7:0] size_lane_mask(input mem_size_e size);
        case (size)
            BYTE:    return 8'h01;
            HALF:    return 8'h03;
            WORD:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [6:0] size_bits(input mem_size_e size);
        case (size)
            BYTE:    return 7'd8;
            HALF:    return 7'd16;
            WORD:    return 7'd32;
            default: return 7'd64;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-wide RAM with per-byte write enables and a registered read port.
// Contents start at zero; nothing but a write ever changes them.
module dmem_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic                         we,
    input  logic [DATA_WIDTH/8-1:0]      be,
    input  logic [$clog2(MEM_DEPTH)-1:0] idx,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH-1:0]        rdata
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};

    // rdata only moves on a load, so it stays put while a response waits.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/sized_data_memory.sv
// Byte/half/word/dword load-store memory behind a valid/ready request and response.
// Define DMEM_MISALIGN_CHECK_EN to fault misaligned accesses instead of aligning them down.
module sized_data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output dmem_state_e           fsm_state
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("sized_data_memory: DATA_WIDTH must be 32 or 64");
    end

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers on a rising edge where rsp_valid && rsp_ready. The
    // request side is only ready in IDLE, so the two never overlap.
    dmem_state_e           state_q, state_d;
    logic                  we_q, uns_q;
    mem_size_e             size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign fsm_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == IDLE && req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= mem_size_e'(req_size);
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Address decode and fault detection, all from the captured request.
    logic [OFF_W-1:0]      lane_raw, lane, align_mask;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  err;

    always_comb begin
        lane_raw   = addr_q[OFF_W-1:0];
        align_mask = OFF_W'((8'd1 << size_q) - 8'd1);
        word_idx   = addr_q >> OFF_W;
        err        = (word_idx >= ADDR_WIDTH'(MEM_DEPTH)) ||
                     (DATA_WIDTH == 32 && size_q == DWORD);
`ifdef DMEM_MISALIGN_CHECK_EN
        lane = lane_raw;
        if ((lane_raw & align_mask) != '0) err = 1'b1;
`else
        lane = lane_raw & ~align_mask;
`endif
    end

    logic                  bank_en;
    logic [NB-1:0]         bank_be;
    logic [DATA_WIDTH-1:0] bank_wdata, bank_rdata;

    // A reset landing in ACCESS drops the state to IDLE, which cancels the write.
    assign bank_en    = (state_q == ACCESS) && !err && !rst;
    assign bank_be    = NB'(size_lane_mask(size_q)) << lane;
    assign bank_wdata = wdata_q << {lane, 3'b000};

    dmem_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_bank (
        .clk   (clk),
        .en    (bank_en),
        .we    (we_q),
        .be    (bank_be),
        .idx   (word_idx[IDX_W-1:0]),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    // Extension: push the field to the top, then shift back arithmetically or
    // logically. Full-width loads shift by zero, so signedness is moot for them.
    logic [DATA_WIDTH-1:0]        shifted, topped, load_val;
    logic signed [DATA_WIDTH-1:0] sext;
    logic [6:0]                   nbits, sh;

    always_comb begin
        shifted  = bank_rdata >> {lane, 3'b000};
        nbits    = size_bits(size_q);
        sh       = (nbits >= 7'(DATA_WIDTH)) ? 7'd0 : 7'(DATA_WIDTH) - nbits;
        topped   = shifted << sh;
        sext     = $signed(topped) >>> sh;
        load_val = uns_q ? (topped >> sh) : sext;
    end

    assign rsp_rdata = (state_q == RESP && !we_q && !err) ? load_val : '0;
    assign rsp_err   = (state_q == RESP) && err;

endmodule

// File: tb/tb_sized_data_memory.sv
// Bench for sized_data_memory: directed scenarios plus randomized traffic checked
// against a byte-addressed reference memory; honours DMEM_MISALIGN_CHECK_EN.
module tb_sized_data_memory;
    import dmem_pkg::*;

    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int DEPTH  = 1024;
    localparam int NBYTES = DEPTH * (DW / 8);

    logic          clk, rst;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, rsp_rdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    dmem_state_e   fsm_state;

    int checks = 0;
    int errors = 0;

    logic [7:0]    model_mem [NBYTES];
    logic [DW-1:0] exp_q[$];
    logic          exp_err_q[$];

    sized_data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .fsm_state    (fsm_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: memory is a flat byte array; an access touches 2**size bytes.
    function automatic void model_op(input logic we, input logic [1:0] size, input logic uns,
                                     input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                     output logic [DW-1:0] rd, output logic err);
        int nb;
        longint unsigned a, val;
        nb  = 1 << size;
        a   = longint'(addr);
        err = 1'b0;
        rd  = '0;
        if (nb * 8 > DW) err = 1'b1;
`ifdef DMEM_MISALIGN_CHECK_EN
        if (a % nb != 0) err = 1'b1;
`else
        a = a - (a % nb);
`endif
        if (a / (DW / 8) >= DEPTH) err = 1'b1;
        if (err) return;
        if (we) begin
            for (int i = 0; i < nb; i++) model_mem[int'(a) + i] = wdata[8*i +: 8];
        end else begin
            val = 0;
            for (int i = 0; i < nb; i++) val |= longint'(model_mem[int'(a) + i]) << (8 * i);
            if (!uns && val[8*nb-1]) val |= ~((64'd1 << (8 * nb)) - 64'd1);
            rd = val[DW-1:0];
        end
    endfunction

    // ---------------- driver ----------------
    // One full transaction; the expectation is queued up front and popped at RESP.
    task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int hold, output logic [DW-1:0] rd, output logic err);
        logic [DW-1:0] e_rd;
        logic          e_err;
        model_op(we, size, uns, addr, wdata, e_rd, e_err);
        exp_q.push_back(e_rd);
        exp_err_q.push_back(e_err);

        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        rsp_ready    = (hold == 0);
        chk("idle_req_ready", req_ready, 1);

        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("access_rsp_valid", rsp_valid, 0);
        chk("access_req_ready", req_ready, 0);

        @(posedge clk); #1;
        e_rd  = exp_q.pop_front();
        e_err = exp_err_q.pop_front();
        chk("resp_rsp_valid", rsp_valid, 1);
        chk("resp_rdata", rsp_rdata, e_rd);
        chk("resp_err", rsp_err, e_err);
        rd  = rsp_rdata;
        err = rsp_err;

        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, e_rd);
            chk("hold_err", rsp_err, e_err);
            chk("hold_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;

        @(posedge clk); #1;
        chk("ret_req_ready", req_ready, 1);
        chk("ret_rsp_valid", rsp_valid, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] rd;
        logic          err;

        for (int i = 0; i < NBYTES; i++) model_mem[i] = 8'h00;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Sign/zero extension of a single byte.
        txn(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, rd, err);
        chk("st_word_rdata", rd, 0);
        txn(0, 2'b00, 0, 32'h13, 0, 0, rd, err);
        chk("lb_signed", rd, 32'hFFFFFFDE);
        txn(0, 2'b00, 1, 32'h13, 0, 0, rd, err);
        chk("lb_unsigned", rd, 32'h000000DE);

        // Half store merges into the existing word.
        txn(1, 2'b01, 0, 32'h12, 32'h00001234, 0, rd, err);
        txn(0, 2'b10, 0, 32'h10, 0, 0, rd, err);
        chk("lw_after_sh", rd, 32'h1234BEEF);
        txn(0, 2'b01, 0, 32'h10, 0, 0, rd, err);
        chk("lh_signed", rd, 32'hFFFFBEEF);

        // Out-of-range index and unsupported dword size.
        txn(0, 2'b10, 0, 32'h1000, 0, 0, rd, err);
        chk("oob_ld_err", err, 1);
        chk("oob_ld_rdata", rd, 0);
        txn(1, 2'b10, 0, 32'h1000, 32'hCAFEF00D, 0, rd, err);
        chk("oob_st_err", err, 1);
        txn(0, 2'b10, 0, 32'h0, 0, 0, rd, err);
        chk("oob_no_alias_write", rd, 0);
        txn(1, 2'b10, 0, 32'hFFC, 32'hA5A55A5A, 0, rd, err);
        txn(0, 2'b10, 0, 32'hFFC, 0, 0, rd, err);
        chk("last_word", rd, 32'hA5A55A5A);
        chk("last_word_err", err, 0);
        txn(0, 2'b11, 0, 32'h10, 0, 0, rd, err);
        chk("dword_on_32_err", err, 1);

        // Misaligned word load.
        txn(0, 2'b10, 0, 32'h11, 0, 0, rd, err);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("misalign_err", err, 1);
        chk("misalign_rdata", rd, 0);
`else
        chk("misalign_err", err, 0);
        chk("misalign_rdata", rd, 32'h1234BEEF);
`endif

        // Consumer stalls for five cycles.
        txn(0, 2'b10, 0, 32'h10, 0, 5, rd, err);
        chk("stall_rdata", rd, 32'h1234BEEF);

        // Reset during ACCESS of a byte store must not write.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h00000055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_access_req_ready", req_ready, 1);
        chk("rst_access_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        txn(0, 2'b00, 1, 32'h10, 0, 0, rd, err);
        chk("aborted_store", rd, 32'h000000EF);

        // Reset during RESP of a store keeps the committed data.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h00000066; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_resp_pre_valid", rsp_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_resp_valid", rsp_valid, 0);
        chk("rst_resp_rdata", rsp_rdata, 0);
        model_mem[32'h20] = 8'h66;
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        txn(0, 2'b00, 0, 32'h20, 0, 0, rd, err);
        chk("resp_rst_kept", rd, 32'h00000066);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(4096, 4200))
                                            : AW'($urandom_range(0, 63));
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, $urandom, $urandom_range(0, 2), rd, err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
